frame_rx_stage: RTL and testbench

FRAME_RX_STAGE -- requirements
Module: frame_rx_stage

---
 rtl/frame_pkg.sv | 16 +
 rtl/crc16_word.sv | 26 ++
 rtl/frame_rx_stage.sv | 179 +++++++++++++++++
 tb/tb_frame_rx_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants and types for the framed word receiver.
// Sync words, CRC parameters and the receive state encoding.
package frame_pkg;

  localparam logic [15:0] HDR      = 16'hE0E0;
  localparam logic [15:0] TRL      = 16'h0E0E;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CHAN = 2'd1,
    DATA = 2'd2
  } rx_state_e;

endpackage

// File: rtl/crc16_word.sv
// Combinational CRC-16/CCITT update over one W-bit word.
// Bits are folded MSB first, no reflection.
module crc16_word
  import frame_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [15:0]  crc_in,
  input  logic [W-1:0] word,
  output logic [15:0]  crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = W - 1; i >= 0; i--) begin
      if (c[15] ^ word[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/frame_rx_stage.sv
// Framed stream receiver: hunts HDR HDR, captures channel and payload,
// checks the trailing CRC and presents whole frames in one output register.
module frame_rx_stage
  import frame_pkg::*;
#(
  parameter int W         = 16,
  parameter int MAX_WORDS = 8,
  parameter int CH_W      = 8,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_n,
  input  logic [W-1:0]                        in_data,
  input  logic                                in_valid,
  output logic [MAX_WORDS*W+CH_W+LEN_W-1:0]   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                crc_err,
  output logic                                len_err,
  output logic                                ovf_err,
  output logic [15:0]                         frames_ok,
  output logic [15:0]                         frames_bad
);

  localparam int OW = MAX_WORDS * W + CH_W + LEN_W;
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_WORDS);

  rx_state_e        r_state, w_state_nx;
  logic             r_hdr, w_hdr_nx;
  logic [W-1:0]     r_la [3];
  logic [1:0]       r_fill;
  logic [W-1:0]     r_pay [MAX_WORDS];
  logic [W-1:0]     w_pay_nx [MAX_WORDS];
  logic [LEN_W-1:0] r_cnt, w_cnt_nx;
  logic [15:0]      r_crc, w_crc_fold, w_crc_nx;
  logic [CH_W-1:0]  r_ch;
  logic [OW-1:0]    r_out, w_frame;
  logic             r_out_valid;
  logic             r_crc_err, r_len_err, r_ovf_err;
  logic [15:0]      r_ok, r_bad;

  logic w_dv, w_shift, w_eof, w_ovf_len;
  logic w_len_err, w_crc_bad, w_good, w_drop;

  crc16_word #(.W(W)) u_crc (
    .crc_in  (r_crc),
    .word    (r_la[2]),
    .crc_out (w_crc_fold)
  );

  // r_la[0] is the newest word, r_la[2] the oldest
  assign w_dv      = in_valid && (r_state == DATA);
  assign w_shift   = w_dv && (r_fill == 2'd3);
  assign w_ovf_len = w_shift && (r_cnt == MAXL);
  assign w_cnt_nx  = r_cnt + LEN_W'(w_shift);
  assign w_crc_nx  = w_shift ? w_crc_fold : r_crc;

  assign w_eof = w_dv && (r_fill >= 2'd2)
              && (in_data == W'(TRL))
              && (r_la[0] == W'(TRL));

  assign w_len_err = w_ovf_len
                  || (w_eof && (w_cnt_nx == '0));
  assign w_crc_bad = !w_ovf_len && w_eof
                  && (w_cnt_nx != '0)
                  && (w_crc_nx != 16'(r_la[1]));
  assign w_good    = !w_ovf_len && w_eof
                  && (w_cnt_nx != '0)
                  && (w_crc_nx == 16'(r_la[1]));
  assign w_drop    = w_good && r_out_valid && !out_ready;

  // Frame image includes the payload word shifted out on this edge
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      w_pay_nx[i] = (w_shift && (r_cnt == LEN_W'(i)))
                  ? r_la[2] : r_pay[i];
      w_frame[OW-1-i*W -: W] = w_pay_nx[i];
    end
    w_frame[LEN_W +: CH_W] = r_ch;
    w_frame[LEN_W-1:0]     = w_cnt_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_hdr_nx   = r_hdr;
    if (in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (r_hdr && (in_data == W'(HDR))) begin
            w_state_nx = CHAN;
            w_hdr_nx   = 1'b0;
          end else begin
            w_hdr_nx = (in_data == W'(HDR));
          end
        end
        CHAN: w_state_nx = DATA;
        DATA: begin
          if (w_ovf_len || w_eof) w_state_nx = HUNT;
        end
        default: w_state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_hdr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hdr   <= w_hdr_nx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_la   <= '{default: '0};
      r_pay  <= '{default: '0};
      r_fill <= '0;
      r_cnt  <= '0;
      r_crc  <= '0;
      r_ch   <= '0;
    end else if (in_valid && (r_state == CHAN)) begin
      r_ch   <= in_data[CH_W-1:0];
      r_crc  <= CRC_INIT;
      r_cnt  <= '0;
      r_fill <= '0;
      r_la   <= '{default: '0};
      r_pay  <= '{default: '0};
    end else if (w_dv) begin
      r_la[2] <= r_la[1];
      r_la[1] <= r_la[0];
      r_la[0] <= in_data;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      if (!w_ovf_len) begin
        r_pay <= w_pay_nx;
        r_cnt <= w_cnt_nx;
        r_crc <= w_crc_nx;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_ok        <= '0;
      r_bad       <= '0;
    end else begin
      r_crc_err <= w_crc_bad;
      r_len_err <= w_len_err;
      r_ovf_err <= w_drop;
      if (w_good && !w_drop) begin
        r_out       <= w_frame;
        r_out_valid <= 1'b1;
        if (r_ok != 16'hFFFF) r_ok <= r_ok + 16'd1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if ((w_len_err || w_crc_bad || w_drop)
          && (r_bad != 16'hFFFF)) begin
        r_bad <= r_bad + 16'd1;
      end
    end
  end

  assign out_data   = r_out;
  assign out_valid  = r_out_valid;
  assign crc_err    = r_crc_err;
  assign len_err    = r_len_err;
  assign ovf_err    = r_ovf_err;
  assign frames_ok  = r_ok;
  assign frames_bad = r_bad;

endmodule

// File: tb/tb_frame_rx_stage.sv
// Bench for frame_rx_stage: queue-based frame model checked every cycle,
// directed frames plus randomized traffic with gaps and backpressure.
module tb_frame_rx_stage;
  import frame_pkg::*;

  localparam int W     = 16;
  localparam int MW    = 8;
  localparam int CH_W  = 8;
  localparam int LEN_W = 4;
  localparam int OW    = MW * W + CH_W + LEN_W;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          crc_err, len_err, ovf_err;
  logic [15:0]   frames_ok, frames_bad;

  always #5 clk_in = ~clk_in;

  frame_rx_stage #(
    .W(W), .MAX_WORDS(MW), .CH_W(CH_W), .LEN_W(LEN_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .ovf_err    (ovf_err),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit rnd_rdy = 1'b0;
  int gap_pct = 0;

  task automatic chk(string name, logic [OW-1:0] act,
                     logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(logic [15:0] c,
                                           logic [7:0] b);
    c = c ^ {b, 8'h00};
    repeat (8) c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

  function automatic logic [15:0] crc_words(input logic [15:0] ws[$]);
    logic [15:0] c = CRC_INIT;
    foreach (ws[i]) begin
      c = crc_byte(c, ws[i][15:8]);
      c = crc_byte(c, ws[i][7:0]);
    end
    return c;
  endfunction

  // Reference model: words after the channel word go into a queue;
  // anything older than the last three is payload.
  int            m_st = 0;
  bit            m_prev = 1'b0;
  logic [15:0]   q[$];
  logic [15:0]   pay[$];
  logic [7:0]    m_ch = '0;
  bit            e_valid = 1'b0;
  bit            e_crc = 1'b0, e_len = 1'b0, e_ovf = 1'b0;
  logic [OW-1:0] e_data = '0;
  int            e_ok = 0, e_bad = 0;

  function automatic logic [OW-1:0] pack();
    logic [OW-1:0] d = '0;
    foreach (pay[i]) d[OW-1-i*W -: W] = pay[i];
    d[LEN_W +: CH_W] = m_ch;
    d[LEN_W-1:0]     = LEN_W'(pay.size());
    return d;
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev = 0; q.delete(); pay.delete(); m_ch = '0;
    e_valid = 0; e_crc = 0; e_len = 0; e_ovf = 0;
    e_data = '0; e_ok = 0; e_bad = 0;
  endtask

  task automatic model_step();
    bit good = 1'b0;
    e_crc = 0; e_len = 0; e_ovf = 0;
    if (in_valid) begin
      case (m_st)
        0: begin
          if (m_prev && in_data == HDR) begin
            m_st = 1; m_prev = 0;
          end else begin
            m_prev = (in_data == HDR);
          end
        end
        1: begin
          m_ch = in_data[7:0]; q.delete(); pay.delete(); m_st = 2;
        end
        default: begin
          q.push_back(in_data);
          if (q.size() > 3) pay.push_back(q.pop_front());
          if (pay.size() > MW) begin
            e_len = 1; m_st = 0;
          end else if (q.size() == 3 && q[1] == TRL && q[2] == TRL) begin
            m_st = 0;
            if (pay.size() == 0) e_len = 1;
            else if (crc_words(pay) != q[0]) e_crc = 1;
            else good = 1;
          end
        end
      endcase
    end
    if (good && e_valid && !out_ready) begin
      e_ovf = 1;
    end else if (good) begin
      e_valid = 1; e_data = pack();
      if (e_ok < 65535) e_ok++;
    end else if (out_ready) begin
      e_valid = 0;
    end
    if ((e_crc || e_len || e_ovf) && e_bad < 65535) e_bad++;
  endtask

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("out_valid", out_valid, e_valid);
      if (e_valid) chk("out_data", out_data, e_data);
      chk("crc_err", crc_err, e_crc);
      chk("len_err", len_err, e_len);
      chk("ovf_err", ovf_err, e_ovf);
      chk("frames_ok", frames_ok, 16'(e_ok));
      chk("frames_bad", frames_bad, 16'(e_bad));
    end
  end

  task automatic drive_rdy();
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(logic [15:0] w);
    while ($urandom_range(0, 99) < gap_pct) begin
      @(negedge clk_in); #1;
      in_valid = 0; in_data = 16'($urandom); drive_rdy();
    end
    @(negedge clk_in); #1;
    in_valid = 1; in_data = w; drive_rdy();
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk_in); #1;
      in_valid = 0; in_data = 16'($urandom); drive_rdy();
    end
  endtask

  task automatic send_q(input logic [15:0] f[$], input int n);
    for (int i = 0; i < n; i++) send_word(f[i]);
  endtask

  task automatic build(input logic [7:0] ch, input logic [7:0] chhi,
                       input logic [15:0] p[$], input logic [15:0] x,
                       output logic [15:0] f[$]);
    f.delete();
    f.push_back(HDR); f.push_back(HDR);
    f.push_back({chhi, ch});
    foreach (p[i]) f.push_back(p[i]);
    f.push_back(crc_words(p) ^ x);
    f.push_back(TRL); f.push_back(TRL);
  endtask

  initial begin
    logic [15:0] f[$];
    logic [15:0] p[$];
    logic [15:0] c, w, x;
    int n, r;

    c = CRC_INIT;
    for (int i = 1; i <= 9; i++) c = crc_byte(c, 8'(48 + i));
    chk("crc_model_123456789", c, 16'h29B1);

    chk_en = 1;
    @(negedge clk_in);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_frames_ok", frames_ok, 16'd0);
    chk("rst_frames_bad", frames_bad, 16'd0);
    chk("rst_errs", {crc_err, len_err, ovf_err}, 3'b000);
    #1 rst_n = 1;

    p = '{16'h1111, 16'h2222};
    build(8'h03, 8'h00, p, 16'h0000, f);
    send_q(f, f.size());
    idle(2);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_payload", out_data[OW-1 -: 32], 32'h1111_2222);
    chk("basic_zero", out_data[OW-33:LEN_W+CH_W], '0);
    chk("basic_ch", out_data[LEN_W +: CH_W], 8'h03);
    chk("basic_len", out_data[LEN_W-1:0], 4'd2);
    chk("basic_ok", frames_ok, 16'd1);
    out_ready = 1; idle(1); out_ready = 0; idle(1);

    build(8'h03, 8'h00, p, 16'h0001, f);
    send_q(f, f.size());
    idle(3);
    chk("crcbad_valid", out_valid, 1'b0);
    chk("crcbad_bad", frames_bad, 16'd1);

    p.delete();
    for (int i = 0; i <= MW; i++) p.push_back(16'(16'h0A00 + i));
    build(8'h21, 8'h00, p, 16'h0000, f);
    send_q(f, f.size());
    idle(2);
    chk("ovflen_bad", frames_bad, 16'd2);
    chk("ovflen_valid", out_valid, 1'b0);
    p = '{16'hBEEF, TRL, HDR};
    build(8'h22, 8'h00, p, 16'h0000, f);
    out_ready = 1;
    send_q(f, f.size());
    idle(3);
    chk("relock_ok", frames_ok, 16'd2);

    out_ready = 0;
    p = '{16'hA001};
    build(8'h31, 8'h00, p, 16'h0000, f);
    send_q(f, f.size());
    p = '{16'hB001, 16'hB002};
    build(8'h32, 8'h00, p, 16'h0000, f);
    send_q(f, f.size());
    idle(2);
    chk("hold_ok", frames_ok, 16'd3);
    chk("hold_bad", frames_bad, 16'd3);
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_first_ch", out_data[LEN_W +: CH_W], 8'h31);
    p = '{16'hC001, 16'hC002, 16'hC003};
    build(8'h33, 8'h00, p, 16'h0000, f);
    send_q(f, f.size() - 1);
    out_ready = 1;
    send_word(f[f.size() - 1]);
    idle(2);
    chk("swap_ok", frames_ok, 16'd4);
    chk("swap_bad", frames_bad, 16'd3);

    gap_pct = 40;
    p = '{16'h1111, 16'h2222};
    build(8'h03, 8'h00, p, 16'h0000, f);
    send_q(f, f.size());
    idle(3);
    gap_pct = 0;
    chk("gaps_ok", frames_ok, 16'd5);

    send_q(f, 5);
    @(negedge clk_in); #1 rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    chk("midrst_ok", frames_ok, 16'd0);
    chk("midrst_bad", frames_bad, 16'd0);
    out_ready = 0;
    send_q(f, f.size());
    idle(2);
    chk("midrst_relock", frames_ok, 16'd1);
    chk("midrst_valid", out_valid, 1'b1);

    rnd_rdy = 1;
    repeat (60) begin
      n = $urandom_range(0, MW + 1);
      p.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        w = 16'($urandom);
        if (r == 0) w = TRL;
        else if (r == 1) w = HDR;
        p.push_back(w);
      end
      gap_pct = $urandom_range(0, 30);
      x = ($urandom_range(0, 4) == 0)
        ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) send_word(16'($urandom));
      end
      build(8'($urandom), 8'($urandom), p, x, f);
      if ($urandom_range(0, 7) == 0)
        send_q(f, $urandom_range(3, f.size() - 1));
      else
        send_q(f, f.size());
      idle($urandom_range(0, 3));
    end
    rnd_rdy = 0;
    gap_pct = 0;
    out_ready = 1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
